// File: rtl/scmp_useq_pkg.sv
// Shared types and constants for the SC/MP microcode sequencer: next-address
// control encodings, sequencer states, microcode entry labels and DLY constants.
package scmp_useq_pkg;

    localparam int UPC_W_PKG = 8;

    typedef logic [UPC_W_PKG-1:0] NEXTPC_t;

    typedef enum logic [2:0] {
        UN_SEQ      = 3'd0,
        UN_JMP      = 3'd1,
        UN_DISPATCH = 3'd2,
        UN_FETCH    = 3'd3,
        UN_WAIT_MEM = 3'd4,
        UN_HALT     = 3'd5
    } UNEXT_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_DLY      = 2'd2,
        ST_HALT     = 2'd3
    } SEQSTATE_t;

    localparam NEXTPC_t UCLBL_RESET   = 8'h00;
    localparam NEXTPC_t UCLBL_FETCH   = 8'h04;
    localparam NEXTPC_t UCLBL_INT     = 8'h08;
    localparam NEXTPC_t UCLBL_DLY     = 8'h10;
    localparam NEXTPC_t UCLBL_ADD     = 8'h20;
    localparam NEXTPC_t UCLBL_ILLEGAL = 8'hFF;

    localparam int DLY_BASE   = 13;
    localparam int DLY_HI_MUL = 514;

    // Sequential successor of a microcode address, wrapping at the top of the ROM.
    function automatic NEXTPC_t upc_inc(input NEXTPC_t pc);
        return pc + 8'd1;
    endfunction

endpackage

// File: rtl/scmp_useq_if.sv
// Sequencer-facing bundle: decoder result, current ROM word control fields,
// bus/interrupt status in; uPC and status flags out.
interface scmp_useq_if;
    import scmp_useq_pkg::*;

    NEXTPC_t    op_pc;
    logic       op_dly;
    logic [2:0] uc_next;
    NEXTPC_t    uc_tgt;
    logic       mem_ack;
    logic [7:0] ac;
    logic [7:0] disp;
    logic       ie;
    logic       sense_a;
    logic       cont;
    NEXTPC_t    upc;
    logic       dly_busy;
    logic       halted;
    logic       int_taken;

    modport master (
        output op_pc, op_dly, uc_next, uc_tgt, mem_ack, ac, disp, ie, sense_a, cont,
        input  upc, dly_busy, halted, int_taken
    );

    modport slave (
        input  op_pc, op_dly, uc_next, uc_tgt, mem_ack, ac, disp, ie, sense_a, cont,
        output upc, dly_busy, halted, int_taken
    );

endinterface

// File: rtl/scmp_useq_dly_counter.sv
// DLY microcycle counter: loads 13 + 2*AC + 514*disp on dispatch, counts down
// one per clock and flags the final cycle of the delay.
module scmp_dly_counter
    import scmp_useq_pkg::*;
#(
    parameter int DLY_W = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       dec_i,
    input  logic [7:0] ac_i,
    input  logic [7:0] disp_i,
    output logic       last_o
);

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;
    logic [DLY_W-1:0] load_val_s;

    assign load_val_s = DLY_W'(DLY_BASE)
                      + (DLY_W'(ac_i) << 1)
                      + (DLY_W'(disp_i) * DLY_W'(DLY_HI_MUL));

    assign last_o = (cnt_q == DLY_W'(1));

    // Next count: operands are captured only on the load cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_s;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DLY_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scmp_useq.sv
// Microcode sequencer: owns the uPC, applies each ROM word's next-address
// control and takes interrupts only at instruction fetch boundaries.
module scmp_useq
    import scmp_useq_pkg::*;
#(
    parameter int DLY_W = 18,
    parameter int UPC_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    scmp_useq_if.slave bus
);

    SEQSTATE_t        state_q, state_d;
    logic [UPC_W-1:0] upc_q, upc_d;
    logic             dly_busy_q, dly_busy_d;
    logic             halted_q, halted_d;
    logic             int_taken_q, int_taken_d;
    logic             dly_load_s;
    logic             dly_dec_s;
    logic             dly_last_s;
    UNEXT_t           unext_s;

    assign unext_s = UNEXT_t'(bus.uc_next);

    scmp_dly_counter #(
        .DLY_W (DLY_W)
    ) u_dly (
        .clk    (clk),
        .rst    (rst),
        .load_i (dly_load_s),
        .dec_i  (dly_dec_s),
        .ac_i   (bus.ac),
        .disp_i (bus.disp),
        .last_o (dly_last_s)
    );

    // Next-state, next-uPC and next-flag decode.
    always_comb begin
        state_d     = state_q;
        upc_d       = upc_q;
        int_taken_d = 1'b0;
        dly_load_s  = 1'b0;
        dly_dec_s   = 1'b0;
        case (state_q)
            ST_RUN: begin
                case (unext_s)
                    UN_SEQ: upc_d = upc_inc(upc_q);
                    UN_JMP: upc_d = bus.uc_tgt;
                    UN_FETCH: begin
                        if (bus.ie && bus.sense_a) begin
                            upc_d       = UCLBL_INT;
                            int_taken_d = 1'b1;
                        end else begin
                            upc_d = UCLBL_FETCH;
                        end
                    end
                    UN_DISPATCH: begin
                        upc_d = bus.op_pc;
                        if (bus.op_dly) begin
                            dly_load_s = 1'b1;
                            state_d    = ST_DLY;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                    UN_WAIT_MEM: begin
                        // A same-cycle ack completes the access without a wait state.
                        if (bus.mem_ack) begin
                            upc_d = upc_inc(upc_q);
                        end else begin
                            state_d = ST_WAIT_MEM;
                        end
                    end
                    UN_HALT: state_d = ST_HALT;
                    default: upc_d = UCLBL_ILLEGAL;
                endcase
            end
            ST_WAIT_MEM: begin
                if (bus.mem_ack) begin
                    upc_d   = upc_inc(upc_q);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT_MEM;
                end
            end
            ST_DLY: begin
                dly_dec_s = 1'b1;
                if (dly_last_s) begin
                    upc_d   = upc_inc(upc_q);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DLY;
                end
            end
            ST_HALT: begin
                if (bus.cont) begin
                    upc_d   = upc_inc(upc_q);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_RUN;
                upc_d   = UCLBL_RESET;
            end
        endcase
        dly_busy_d = (state_d == ST_DLY);
        halted_d   = (state_d == ST_HALT);
    end

    // State, uPC and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            upc_q       <= UCLBL_RESET;
            dly_busy_q  <= 1'b0;
            halted_q    <= 1'b0;
            int_taken_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            upc_q       <= upc_d;
            dly_busy_q  <= dly_busy_d;
            halted_q    <= halted_d;
            int_taken_q <= int_taken_d;
        end
    end

    assign bus.upc       = upc_q;
    assign bus.dly_busy  = dly_busy_q;
    assign bus.halted    = halted_q;
    assign bus.int_taken = int_taken_q;

endmodule

// File: tb/tb_scmp_useq.sv
// Directed bench for scmp_useq: sequencing, dispatch, DLY length, memory wait,
// interrupt entry, illegal encodings, reset mid-DLY and halt/continue.
module tb_scmp_useq;
    import scmp_useq_pkg::*;

    logic clk;
    logic rst;
    int   checks_n;
    int   errors_n;
    int   cyc_n;
    logic held_ok;
    logic int_seen;

    scmp_useq_if bus ();

    scmp_useq #(
        .DLY_W (18),
        .UPC_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_n = 0;
        errors_n = 0;
        rst = 1'b1;
        bus.op_pc   = 8'h00;
        bus.op_dly  = 1'b0;
        bus.uc_next = 3'd0;
        bus.uc_tgt  = 8'h00;
        bus.mem_ack = 1'b0;
        bus.ac      = 8'h00;
        bus.disp    = 8'h00;
        bus.ie      = 1'b0;
        bus.sense_a = 1'b0;
        bus.cont    = 1'b0;
        step();
        step();
        check("rst_upc", 32'(bus.upc), 32'h00);
        check("rst_flags", {bus.dly_busy, bus.halted, bus.int_taken}, 32'd0);

        // Sequential stepping from the reset label
        rst = 1'b0;
        bus.uc_next = 3'd0;
        step(); check("seq1", 32'(bus.upc), 32'h01);
        step(); check("seq2", 32'(bus.upc), 32'h02);
        step(); check("seq3", 32'(bus.upc), 32'h03);
        check("seq_flags", {bus.dly_busy, bus.halted, bus.int_taken}, 32'd0);

        // Plain dispatch
        bus.uc_next = 3'd2; bus.op_pc = UCLBL_ADD; bus.op_dly = 1'b0;
        step();
        check("disp_upc", 32'(bus.upc), 32'h20);
        check("disp_busy", 32'(bus.dly_busy), 32'd0);

        // DLY with ac=2, disp=1 -> 531 busy cycles; later operand/interrupt changes ignored
        bus.op_pc = UCLBL_DLY; bus.op_dly = 1'b1; bus.ac = 8'h02; bus.disp = 8'h01;
        step();
        bus.ac = 8'hFF; bus.disp = 8'hFF; bus.op_dly = 1'b0;
        bus.uc_next = 3'd3; bus.ie = 1'b1; bus.sense_a = 1'b1;
        cyc_n = 0; held_ok = 1'b1; int_seen = 1'b0;
        while (bus.dly_busy && cyc_n < 1000) begin
            cyc_n++;
            if (bus.upc !== UCLBL_DLY) held_ok = 1'b0;
            if (bus.int_taken) int_seen = 1'b1;
            step();
        end
        bus.ie = 1'b0; bus.sense_a = 1'b0;
        check("dly_len", 32'(cyc_n), 32'd531);
        check("dly_hold", 32'(held_ok), 32'd1);
        check("dly_noint", 32'(int_seen), 32'd0);
        check("dly_exit_upc", 32'(bus.upc), 32'h11);

        // Memory wait: ack three cycles late
        bus.uc_next = 3'd1; bus.uc_tgt = 8'h40;
        step(); check("jmp_upc", 32'(bus.upc), 32'h40);
        bus.uc_next = 3'd4;
        step(); check("wait_h1", 32'(bus.upc), 32'h40);
        bus.uc_next = 3'd0;
        step(); check("wait_h2", 32'(bus.upc), 32'h40);
        step(); check("wait_h3", 32'(bus.upc), 32'h40);
        bus.mem_ack = 1'b1;
        step(); check("wait_done", 32'(bus.upc), 32'h41);
        bus.uc_next = 3'd4;
        step(); check("wait_zero", 32'(bus.upc), 32'h42);
        bus.uc_next = 3'd1; bus.uc_tgt = 8'h50;
        step(); check("jmp_ack_ign", 32'(bus.upc), 32'h50);
        bus.mem_ack = 1'b0; bus.uc_next = 3'd0;
        step(); check("seq_after", 32'(bus.upc), 32'h51);

        // Fetch with and without interrupt
        bus.uc_next = 3'd3; bus.ie = 1'b1; bus.sense_a = 1'b1;
        step();
        check("int_upc", 32'(bus.upc), 32'h08);
        check("int_pulse", 32'(bus.int_taken), 32'd1);
        bus.uc_next = 3'd0; bus.ie = 1'b0;
        step();
        check("int_pulse_end", 32'(bus.int_taken), 32'd0);
        check("int_seq", 32'(bus.upc), 32'h09);
        bus.uc_next = 3'd3;
        step();
        check("fetch_upc", 32'(bus.upc), 32'h04);
        check("fetch_noint", 32'(bus.int_taken), 32'd0);
        bus.sense_a = 1'b0;

        // Unused encoding goes to the illegal label, then uPC wraps
        bus.uc_next = 3'd7;
        step(); check("illegal", 32'(bus.upc), 32'hFF);
        bus.uc_next = 3'd0;
        step(); check("wrap", 32'(bus.upc), 32'h00);

        // Reset in the middle of a DLY (ac=0, disp=1 -> 527, reset at count 100)
        bus.uc_next = 3'd2; bus.op_pc = UCLBL_DLY; bus.op_dly = 1'b1;
        bus.ac = 8'h00; bus.disp = 8'h01;
        step();
        check("dly2_busy", 32'(bus.dly_busy), 32'd1);
        bus.uc_next = 3'd0; bus.op_dly = 1'b0;
        repeat (427) step();
        check("dly2_still", 32'(bus.dly_busy), 32'd1);
        rst = 1'b1;
        step();
        check("rst_dly_upc", 32'(bus.upc), 32'h00);
        check("rst_dly_busy", 32'(bus.dly_busy), 32'd0);
        rst = 1'b0;
        step(); check("rst_dly_seq", 32'(bus.upc), 32'h01);

        // Halt for five cycles, then continue
        bus.uc_next = 3'd1; bus.uc_tgt = 8'h30;
        step();
        bus.uc_next = 3'd5;
        step();
        check("halt_upc", 32'(bus.upc), 32'h30);
        bus.uc_next = 3'd0;
        cyc_n = 0;
        while (bus.halted && cyc_n < 50) begin
            cyc_n++;
            if (cyc_n == 5) bus.cont = 1'b1;
            step();
        end
        bus.cont = 1'b0;
        check("halt_len", 32'(cyc_n), 32'd5);
        check("halt_resume", 32'(bus.upc), 32'h31);
        check("halt_clear", 32'(bus.halted), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule
